elevator_trip_scheduler: RTL and testbench
==========================================

// Module: elevator_trip_scheduler
// PURPOSE
//  Queues trip requests (pickup floor, destination floor) from the push-button capture block and sequences the car.
//  Each trip runs in order: move to pickup, hold door, move to destination, hold door.
//  Sits between button capture and motor/door drivers; owns the car position register.
// PARAMETERS
//  NUM_FLOORS   9    highest valid floor; floors numbered 1..NUM_FLOORS
//  FLOOR_TICKS  25000000  clk cycles to travel one floor (bench uses 4)
//  DOOR_TICKS   50000000  clk cycles door held open per stop (bench uses 3)
//  FIFO_DEPTH   4    queued trips; power of 2, >=2
// PORTS
//  clk          in   1   system clock, all logic on posedge
//  rst_n        in   1   synchronous active-low reset
//  req_current  in   5   pickup floor from button capture
//  req_dest     in   5   destination floor from button capture
//  req_confirm  in   1   level from button capture; rising edge = new trip
//  car_floor    out  5   current car floor, 1..NUM_FLOORS
//  motor_up     out  1   car travelling up
//  motor_down   out  1   car travelling down
//  door_open    out  1   door held open at a stop
//  busy         out  1   state!=IDLE or queue non-empty
//  trip_done    out  1   1-cycle pulse at end of destination door hold
//  req_drop     out  1   1-cycle pulse: valid trip lost, queue full
//  req_err      out  1   1-cycle pulse: trip rejected, floor out of range
//  queue_count  out  $clog2(FIFO_DEPTH+1)  trips waiting (excl. one in service)
// BEHAVIOUR
//  Reset (rst_n=0 at posedge): car_floor=1; all other outputs 0; queue empty; timers 0; state IDLE.
//  Reset mid-trip aborts the trip and snaps car_floor to 1 (no position retention).
//  Edge detect: confirm_q <= req_confirm; new = req_confirm & ~confirm_q. Held-high = one trip.
//  Validation on new: req_current or req_dest outside 1..NUM_FLOORS -> req_err next cycle, no push.
//   Otherwise push {req_current,req_dest}; full -> req_drop next cycle, no push.
//   req_current==req_dest is valid: both stops served with zero travel.
//  Push and pop in the same cycle are both honoured. Full is evaluated after the pop, so push when full+pop is accepted.
//  FSM states:
//   IDLE       : queue non-empty -> LOAD
//   LOAD       : pop head into pick/dst regs -> MOVE_PICK
//   MOVE_PICK  : target=pick
//   DOOR_PICK  : -> MOVE_DST
//   MOVE_DST   : target=dst
//   DOOR_DST   : trip_done pulse on exit; -> IDLE
//  MOVE_x rules:
//   car_floor==target -> DOOR_x next cycle; motors 0.
//   else motor_up=(target>car_floor), motor_down=(target<car_floor); timer counts 0..FLOOR_TICKS-1.
//   At FLOOR_TICKS-1: car_floor+/-1, timer=0.
//   Motors never both 1. Motors are 0 in all non-MOVE states.
//  DOOR_x: door_open=1 exactly DOOR_TICKS cycles, then next state; door_open=0 elsewhere.
//  Latency from edge to motion: edge cycle, push (+1), IDLE->LOAD (+1), LOAD->MOVE (+1).
//   So the first motor assertion comes 3 cycles after the edge is sampled.
//  Travel of N floors = N*FLOOR_TICKS cycles + 1 arrival-decision cycle.
//  Requests keep queuing during service; no reordering, strict FIFO.
//  car_floor stays within 1..NUM_FLOORS at all times.
// TESTING (FLOOR_TICKS=4, DOOR_TICKS=3, FIFO_DEPTH=4)
//  Reset, then trip 3->5:
//   motor_up for 8 cycles reaching floor 3; door_open 3 cycles.
//   motor_up 8 cycles to floor 5; door_open 3 cycles; trip_done once; busy=0.
//  Trip 1->1: no motor activity; two 3-cycle door holds; trip_done; car_floor stays 1.
//  During trip, issue 5 more edges (2->4 each): queue_count climbs to 4; 5th edge -> req_drop pulse, count stays 4.
//  Trip 0->4 and trip 3->10: req_err pulse each; queue_count unchanged; no motion.
//  req_confirm held high 20 cycles: exactly one trip queued.
//  Trip 9->1 from floor 1: up 32 cycles, door, down 32 cycles.
//   Assert rst_n=0 mid-descent: all outputs 0, car_floor=1, queue empty next cycle.

Source files
------------

// File: rtl/elevator_trip_if.sv
// Trip request bus from the push-button capture block into the scheduler.
interface elevator_trip_if;
    logic [4:0] req_current;
    logic [4:0] req_dest;
    logic       req_confirm;

    modport master (output req_current, req_dest, req_confirm);
    modport slave  (input  req_current, req_dest, req_confirm);
endinterface

// File: rtl/elevator_trip_scheduler.sv
// Queues pickup/destination trips and sequences the car: move to pickup, door, move to
// destination, door. Owns the car position register.
module elevator_trip_scheduler #(
    parameter int NUM_FLOORS  = 9,
    parameter int FLOOR_TICKS = 25000000,
    parameter int DOOR_TICKS  = 50000000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                               i_clk,
    input  logic                               i_rst_n,
    elevator_trip_if.slave                     i_req,
    output logic [4:0]                         o_car_floor,
    output logic                               o_motor_up,
    output logic                               o_motor_down,
    output logic                               o_door_open,
    output logic                               o_busy,
    output logic                               o_trip_done,
    output logic                               o_req_drop,
    output logic                               o_req_err,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_queue_count
);
    localparam int AW        = $clog2(FIFO_DEPTH);
    localparam int CW        = $clog2(FIFO_DEPTH + 1);
    localparam int MAX_TICKS = (FLOOR_TICKS > DOOR_TICKS) ? FLOOR_TICKS : DOOR_TICKS;
    localparam int TW        = $clog2(MAX_TICKS + 1);

    localparam logic [TW-1:0] FLOOR_LAST = TW'(FLOOR_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST  = TW'(DOOR_TICKS - 1);
    localparam logic [4:0]    TOP_FLOOR  = 5'(NUM_FLOORS);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [4:0] pick;
        logic [4:0] dst;
    } trip_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MOVE_PICK,
        S_DOOR_PICK,
        S_MOVE_DST,
        S_DOOR_DST
    } state_t;

    state_t        r_state;
    trip_t         r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_confirm_q;
    logic          r_req_err;
    logic          r_req_drop;

    logic [4:0]    r_car;
    logic [4:0]    r_pick;
    logic [4:0]    r_dst;
    logic [TW-1:0] r_timer;
    logic          r_up;
    logic          r_down;
    logic          r_door;
    logic          r_done;

    logic          w_new;
    logic          w_in_range;
    logic          w_pop;
    logic          w_full;
    logic          w_push;
    trip_t         w_head;
    trip_t         w_wdata;
    logic [4:0]    w_target;

    assign w_new      = i_req.req_confirm & ~r_confirm_q;
    assign w_in_range = (i_req.req_current >= 5'd1) && (i_req.req_current <= TOP_FLOOR) &&
                        (i_req.req_dest    >= 5'd1) && (i_req.req_dest    <= TOP_FLOOR);
    assign w_pop      = (r_state == S_LOAD);
    // A slot freed by this cycle's pop is usable by this cycle's push.
    assign w_full     = (r_count == DEPTH_C) && !w_pop;
    assign w_push     = w_new && w_in_range && !w_full;
    assign w_head     = r_mem[r_rd_ptr];
    assign w_wdata    = '{pick: i_req.req_current, dst: i_req.req_dest};
    assign w_target   = (r_state == S_MOVE_DST) ? r_dst : r_pick;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_confirm_q <= 1'b0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_req_err   <= 1'b0;
            r_req_drop  <= 1'b0;
        end else begin
            r_confirm_q <= i_req.req_confirm;
            r_req_err   <= w_new && !w_in_range;
            r_req_drop  <= w_new && w_in_range && w_full;
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_car   <= 5'd1;
            r_pick  <= 5'd1;
            r_dst   <= 5'd1;
            r_timer <= '0;
            r_up    <= 1'b0;
            r_down  <= 1'b0;
            r_door  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_pick  <= w_head.pick;
                    r_dst   <= w_head.dst;
                    r_timer <= '0;
                    r_state <= S_MOVE_PICK;
                end
                S_MOVE_PICK, S_MOVE_DST: begin
                    // Arrival costs one decision cycle with motors already off.
                    if (r_car == w_target) begin
                        r_up    <= 1'b0;
                        r_down  <= 1'b0;
                        r_door  <= 1'b1;
                        r_timer <= '0;
                        r_state <= (r_state == S_MOVE_PICK) ? S_DOOR_PICK : S_DOOR_DST;
                    end else begin
                        r_up   <= (w_target > r_car);
                        r_down <= (w_target < r_car);
                        if (r_timer == FLOOR_LAST) begin
                            r_timer <= '0;
                            r_car   <= (w_target > r_car) ? r_car + 5'd1 : r_car - 5'd1;
                        end else begin
                            r_timer <= r_timer + TW'(1);
                        end
                    end
                end
                S_DOOR_PICK, S_DOOR_DST: begin
                    if (r_timer == DOOR_LAST) begin
                        r_door  <= 1'b0;
                        r_timer <= '0;
                        if (r_state == S_DOOR_PICK) begin
                            r_state <= S_MOVE_DST;
                        end else begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_car_floor   = r_car;
    assign o_motor_up    = r_up;
    assign o_motor_down  = r_down;
    assign o_door_open   = r_door;
    assign o_busy        = (r_state != S_IDLE) || (r_count != '0);
    assign o_trip_done   = r_done;
    assign o_req_drop    = r_req_drop;
    assign o_req_err     = r_req_err;
    assign o_queue_count = r_count;

    a_motor_excl: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(r_up && r_down));
    a_car_range:  assert property (@(posedge i_clk) disable iff (!i_rst_n)
                                   (r_car >= 5'd1) && (r_car <= TOP_FLOOR));
    a_count_max:  assert property (@(posedge i_clk) disable iff (!i_rst_n) r_count <= DEPTH_C);
endmodule

// File: tb/tb_elevator_trip_scheduler.sv
// Bench for elevator_trip_scheduler: trip table, hand-built corner sequences, and random
// traffic checked cycle by cycle against a trip-timeline model.
module tb_elevator_trip_scheduler;
    localparam int NF = 9;
    localparam int FT = 4;
    localparam int DT = 3;
    localparam int FD = 4;
    localparam int CW = $clog2(FD + 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    elevator_trip_if ifc();

    logic [4:0]    car;
    logic          up, dn, door, busy, done, drop, err;
    logic [CW-1:0] qc;

    elevator_trip_scheduler #(
        .NUM_FLOORS(NF), .FLOOR_TICKS(FT), .DOOR_TICKS(DT), .FIFO_DEPTH(FD)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(ifc),
        .o_car_floor(car), .o_motor_up(up), .o_motor_down(dn), .o_door_open(door),
        .o_busy(busy), .o_trip_done(done), .o_req_drop(drop), .o_req_err(err),
        .o_queue_count(qc)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.req_confirm = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic chk_idle_state(input string tag);
        chk({tag, " car_floor"}, car, 1);
        chk({tag, " motor_up"}, up, 0);
        chk({tag, " motor_down"}, dn, 0);
        chk({tag, " door_open"}, door, 0);
        chk({tag, " busy"}, busy, 0);
        chk({tag, " trip_done"}, done, 0);
        chk({tag, " req_drop"}, drop, 0);
        chk({tag, " req_err"}, err, 0);
        chk({tag, " queue_count"}, qc, 0);
    endtask

    // ---------------- trip-timeline reference model ----------------
    typedef struct {
        int push, pop, start, done, from, pick, dst;
    } mtrip_t;

    mtrip_t mq[$];
    int  m_err_at, m_drop_at, m_last_done, m_last_floor, cyc;
    bit  pconf;

    task automatic model_edge(input int t, input int p, input int d);
        int cnt;
        mtrip_t tr;
        if (p < 1 || p > NF || d < 1 || d > NF) begin
            m_err_at = t;
            return;
        end
        cnt = 0;
        foreach (mq[i]) if (mq[i].push < t && mq[i].pop > t) cnt++;
        if (cnt >= FD) begin
            m_drop_at = t;
            return;
        end
        tr.push  = t;
        tr.from  = m_last_floor;
        tr.pick  = p;
        tr.dst   = d;
        tr.start = (t > m_last_done) ? t + 3 : m_last_done + 3;
        tr.pop   = tr.start - 1;
        tr.done  = tr.start + iabs(p - tr.from) * FT + 2 * DT + 1 + iabs(d - p) * FT;
        m_last_done  = tr.done;
        m_last_floor = d;
        mq.push_back(tr);
    endtask

    task automatic check_cycle(input int t);
        int ecar, eqc, s, a, b, n, k;
        bit eup, edn, edoor, edone, ebusy;
        ecar = 1; eqc = 0; eup = 0; edn = 0; edoor = 0; edone = 0; ebusy = 0;
        foreach (mq[i]) begin
            if (mq[i].push <= t && mq[i].pop > t)  eqc++;
            if (mq[i].push <= t && mq[i].done > t) ebusy = 1;
            if (mq[i].done == t) edone = 1;
            for (int leg = 0; leg < 2; leg++) begin
                a = (leg == 0) ? mq[i].from : mq[i].pick;
                b = (leg == 0) ? mq[i].pick : mq[i].dst;
                s = (leg == 0) ? mq[i].start
                               : mq[i].start + iabs(mq[i].pick - mq[i].from) * FT + DT + 1;
                if (t >= s) begin
                    n = iabs(b - a);
                    k = (t - s + 1) / FT;
                    if (k > n) k = n;
                    ecar = (b > a) ? a + k : a - k;
                    if (t < s + n * FT) begin
                        eup = (b > a);
                        edn = (b < a);
                    end else if (t < s + n * FT + DT) begin
                        edoor = 1;
                    end
                end
            end
        end
        chk($sformatf("c%0d car_floor", t), car, ecar);
        chk($sformatf("c%0d motor_up", t), up, eup);
        chk($sformatf("c%0d motor_down", t), dn, edn);
        chk($sformatf("c%0d door_open", t), door, edoor);
        chk($sformatf("c%0d trip_done", t), done, edone);
        chk($sformatf("c%0d busy", t), busy, ebusy);
        chk($sformatf("c%0d queue_count", t), qc, eqc);
        chk($sformatf("c%0d req_err", t), err, (m_err_at == t) ? 1 : 0);
        chk($sformatf("c%0d req_drop", t), drop, (m_drop_at == t) ? 1 : 0);
    endtask

    task automatic step();
        bit c;
        int p, d;
        c = ifc.req_confirm;
        p = ifc.req_current;
        d = ifc.req_dest;
        @(posedge clk);
        cyc++;
        if (c && !pconf) model_edge(cyc, p, d);
        pconf = c;
        #1 check_cycle(cyc);
    endtask

    function automatic logic [4:0] rnd_floor();
        int v;
        v = $urandom_range(0, 19);
        if (v < 18) return 5'(1 + v % 9);
        if (v == 18) return 5'd0;
        return 5'($urandom_range(10, 31));
    endfunction

    // ---------------- directed trip table ----------------
    typedef struct {
        int pick, dst, err, up, dn, door, done, fin, qmax;
    } vec_t;

    vec_t vt[7];

    initial begin
        int n_up, n_dn, n_door, n_done, n_err, n_drop, qmax;
        bit fin;
        int rates[5];

        ifc.req_current = 5'd1;
        ifc.req_dest    = 5'd1;
        ifc.req_confirm = 1'b0;

        vt[0] = '{1, 1,  0,  0,  0, 6, 1, 1, 1};
        vt[1] = '{3, 5,  0, 16,  0, 6, 1, 5, 1};
        vt[2] = '{0, 4,  1,  0,  0, 0, 0, 5, 0};
        vt[3] = '{3, 10, 1,  0,  0, 0, 0, 5, 0};
        vt[4] = '{5, 2,  0,  0, 12, 6, 1, 2, 1};
        vt[5] = '{9, 9,  0, 28,  0, 6, 1, 9, 1};
        vt[6] = '{4, 7,  0, 12, 20, 6, 1, 7, 1};

        do_reset();
        chk_idle_state("reset");

        foreach (vt[r]) begin
            ifc.req_current = 5'(vt[r].pick);
            ifc.req_dest    = 5'(vt[r].dst);
            ifc.req_confirm = 1'b1;
            n_up = 0; n_dn = 0; n_door = 0; n_done = 0; n_err = 0; n_drop = 0; qmax = 0;
            fin = 0;
            for (int k = 0; k < 400; k++) begin
                @(posedge clk);
                #1;
                if (k == 0) ifc.req_confirm = 1'b0;
                n_up += int'(up); n_dn += int'(dn); n_door += int'(door);
                n_done += int'(done); n_err += int'(err); n_drop += int'(drop);
                if (int'(qc) > qmax) qmax = int'(qc);
                if (k >= 3 && !busy) begin
                    fin = 1;
                    break;
                end
            end
            chk($sformatf("row%0d finished", r), fin, 1);
            chk($sformatf("row%0d req_err", r), n_err, vt[r].err);
            chk($sformatf("row%0d req_drop", r), n_drop, 0);
            chk($sformatf("row%0d up cycles", r), n_up, vt[r].up);
            chk($sformatf("row%0d down cycles", r), n_dn, vt[r].dn);
            chk($sformatf("row%0d door cycles", r), n_door, vt[r].door);
            chk($sformatf("row%0d trip_done", r), n_done, vt[r].done);
            chk($sformatf("row%0d final floor", r), car, vt[r].fin);
            chk($sformatf("row%0d max queue", r), qmax, vt[r].qmax);
        end

        // Confirm held high for 20 cycles must queue only one trip.
        ifc.req_current = 5'd7;
        ifc.req_dest    = 5'd7;
        ifc.req_confirm = 1'b1;
        n_done = 0; n_drop = 0; n_err = 0; qmax = 0; fin = 0;
        for (int k = 0; k < 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 19) ifc.req_confirm = 1'b0;
            n_done += int'(done); n_drop += int'(drop); n_err += int'(err);
            if (int'(qc) > qmax) qmax = int'(qc);
            if (k >= 22 && !busy) begin
                fin = 1;
                break;
            end
        end
        chk("held finished", fin, 1);
        chk("held trip_done", n_done, 1);
        chk("held max queue", qmax, 1);
        chk("held drop+err", n_drop + n_err, 0);

        // Long trip 1->9 in service while five 2->4 edges arrive; fifth is dropped.
        ifc.req_current = 5'd1;
        ifc.req_dest    = 5'd9;
        ifc.req_confirm = 1'b1;
        n_drop = 0;
        for (int k = 0; k <= 16; k++) begin
            @(posedge clk);
            #1;
            n_drop += int'(drop);
            if (k >= 6 && k <= 14 && k % 2 == 0) begin
                chk($sformatf("fill edge%0d queue_count", (k - 6) / 2), qc,
                    ((k - 6) / 2 + 1 > 4) ? 4 : (k - 6) / 2 + 1);
                chk($sformatf("fill edge%0d req_drop", (k - 6) / 2), drop, (k == 14) ? 1 : 0);
            end
            ifc.req_current = 5'd2;
            ifc.req_dest    = 5'd4;
            ifc.req_confirm = ((k + 1) >= 6 && (k + 1) <= 14 && (k + 1) % 2 == 0);
        end
        chk("fill total drops", n_drop, 1);
        chk("fill busy", busy, 1);

        ifc.req_confirm = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_idle_state("reset with full queue");
        rst_n = 1'b1;

        // Trip 9->1 from floor 1, reset during descent.
        ifc.req_current = 5'd9;
        ifc.req_dest    = 5'd1;
        ifc.req_confirm = 1'b1;
        n_up = 0; n_dn = 0; n_door = 0;
        for (int k = 0; k <= 48; k++) begin
            @(posedge clk);
            #1;
            if (k == 0) ifc.req_confirm = 1'b0;
            if (k <= 38) begin
                n_up += int'(up); n_dn += int'(dn); n_door += int'(door);
            end
            if (k == 38) chk("9to1 car at pickup", car, 9);
            if (k == 48) begin
                chk("9to1 descending", dn, 1);
                chk("9to1 floor mid-descent", car, 7);
            end
        end
        chk("9to1 up cycles", n_up, 32);
        chk("9to1 door cycles", n_door, 3);
        chk("9to1 down before door end", n_dn, 0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk_idle_state("reset mid-descent");
        rst_n = 1'b1;

        // Random traffic against the timeline model.
        do_reset();
        mq.delete();
        m_err_at = -1; m_drop_at = -1; m_last_done = -100; m_last_floor = 1;
        cyc = 0; pconf = 0;
        rates = '{3, 20, 50, 5, 35};
        for (int blk = 0; blk < 5; blk++) begin
            for (int j = 0; j < 600; j++) begin
                ifc.req_confirm = ($urandom_range(0, 99) < rates[blk]);
                ifc.req_current = rnd_floor();
                ifc.req_dest    = rnd_floor();
                step();
            end
        end
        ifc.req_confirm = 1'b0;
        for (int g = 0; g < 3000 && cyc <= m_last_done + 4; g++) step();
        chk("random drained", (cyc > m_last_done + 4) ? 1 : 0, 1);
        chk("random trips accepted", (mq.size() > 20) ? 1 : 0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
